// File: rtl/decode_buffer.sv
// decode_buffer: RV32I decoder feeding a DEPTH-entry circular FIFO of decoded records.
// Records leave through a valid/ready port; flush and reset discard everything buffered.
package decode_buffer_pkg;

    localparam logic [1:0] FU_ALU    = 2'd0;
    localparam logic [1:0] FU_LSU    = 2'd1;
    localparam logic [1:0] FU_BRANCH = 2'd2;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [2:0]  ALUOp;
        logic [6:0]  Opcode;
        logic [1:0]  fu;
    } decode_data;

endpackage

module decode_buffer
    import decode_buffer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic [31:0]              instr,
    input  logic [31:0]              pc_in,
    input  logic                     valid_in,
    output logic                     ready_in,
    output logic                     valid_out,
    input  logic                     ready_out,
    output decode_data               data_out,
    output logic                     illegal_out,
    output logic [$clog2(DEPTH):0]   count
);

    // DEPTH must be a power of two so the pointers wrap by plain overflow.
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I_ALU  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;

    logic push;
    logic pop;

    decode_data dec;
    logic       dec_illegal;

    logic [4:0]  f_rd;
    logic [4:0]  f_rs1;
    logic [4:0]  f_rs2;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;

    assign f_rd  = instr[11:7];
    assign f_rs1 = instr[19:15];
    assign f_rs2 = instr[24:20];
    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    // Fields a format does not use stay at the zero default.
    always_comb begin
        dec         = '0;
        dec_illegal = 1'b0;
        dec.pc      = pc_in;
        dec.Opcode  = instr[6:0];
        case (instr[6:0])
            OP_R: begin
                dec.rs1 = f_rs1; dec.rs2 = f_rs2; dec.rd = f_rd;
                dec.ALUOp = 3'b010; dec.fu = FU_ALU;
            end
            OP_I_ALU: begin
                dec.rs1 = f_rs1; dec.rd = f_rd; dec.imm = imm_i;
                dec.ALUOp = 3'b011; dec.fu = FU_ALU;
            end
            OP_LOAD: begin
                dec.rs1 = f_rs1; dec.rd = f_rd; dec.imm = imm_i;
                dec.ALUOp = 3'b000; dec.fu = FU_LSU;
            end
            OP_STORE: begin
                dec.rs1 = f_rs1; dec.rs2 = f_rs2; dec.imm = imm_s;
                dec.ALUOp = 3'b000; dec.fu = FU_LSU;
            end
            OP_BRANCH: begin
                dec.rs1 = f_rs1; dec.rs2 = f_rs2; dec.imm = imm_b;
                dec.ALUOp = 3'b001; dec.fu = FU_BRANCH;
            end
            OP_LUI: begin
                dec.rd = f_rd; dec.imm = imm_u;
                dec.ALUOp = 3'b100; dec.fu = FU_ALU;
            end
            OP_AUIPC: begin
                dec.rd = f_rd; dec.imm = imm_u;
                dec.ALUOp = 3'b101; dec.fu = FU_ALU;
            end
            OP_JALR: begin
                dec.rs1 = f_rs1; dec.rd = f_rd; dec.imm = imm_i;
                dec.ALUOp = 3'b110; dec.fu = FU_BRANCH;
            end
            OP_JAL: begin
                dec.rd = f_rd; dec.imm = imm_j;
                dec.ALUOp = 3'b111; dec.fu = FU_BRANCH;
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    // ready_in ignores ready_out, so a full buffer refuses a push even while popping.
    assign ready_in  = !reset && !flush && (count_reg < FULL_COUNT);
    assign valid_out = (count_reg != '0);
    assign push      = valid_in && ready_in;
    assign pop       = valid_out && ready_out;

    decode_data       entry_data [DEPTH];
    logic [DEPTH-1:0] entry_illegal;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        decode_data data_reg;
        logic       illegal_reg;

        always_ff @(posedge clk) begin
            if (push && (wr_ptr_reg == PTR_W'(gi))) begin
                data_reg    <= dec;
                illegal_reg <= dec_illegal;
            end
        end

        assign entry_data[gi]    = data_reg;
        assign entry_illegal[gi] = illegal_reg;
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            if (push && !pop)
                count_reg <= count_reg + CNT_W'(1);
            else if (pop && !push)
                count_reg <= count_reg - CNT_W'(1);
        end
    end

    // Empty buffer presents an all-zero record so stale entries never leak out.
    assign data_out    = valid_out ? entry_data[rd_ptr_reg] : '0;
    assign illegal_out = valid_out ? entry_illegal[rd_ptr_reg] : 1'b0;
    assign count       = count_reg;

endmodule

// File: tb/tb_decode_buffer.sv
// Directed testbench for decode_buffer: hand-decoded RV32I vectors, FIFO ordering,
// backpressure, wrap-around, flush, illegal opcode and mid-run reset.
module tb_decode_buffer;
    import decode_buffer_pkg::*;

    localparam int DEPTH = 4;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   flush;
    logic [31:0]            instr;
    logic [31:0]            pc_in;
    logic                   valid_in;
    logic                   ready_in;
    logic                   valid_out;
    logic                   ready_out;
    decode_data             data_out;
    logic                   illegal_out;
    logic [$clog2(DEPTH):0] count;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [2:0]  aluop;
    } vec_t;

    vec_t vec [9];

    decode_buffer #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .instr       (instr),
        .pc_in       (pc_in),
        .valid_in    (valid_in),
        .ready_in    (ready_in),
        .valid_out   (valid_out),
        .ready_out   (ready_out),
        .data_out    (data_out),
        .illegal_out (illegal_out),
        .count       (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int i);
        instr    = vec[i].instr;
        pc_in    = vec[i].pc;
        valid_in = 1'b1;
    endtask

    task automatic check_head(input int i);
        logic [31:0] w;
        w = vec[i].instr;
        $display("head v%0d instr=%h pc=%h rs1=%0d rs2=%0d rd=%0d imm=%h aluop=%0d",
                 i, w, data_out.pc, data_out.rs1, data_out.rs2, data_out.rd,
                 data_out.imm, data_out.ALUOp);
        check($sformatf("v%0d.valid", i),   32'(valid_out),       32'd1);
        check($sformatf("v%0d.illegal", i), 32'(illegal_out),     32'd0);
        check($sformatf("v%0d.pc", i),      data_out.pc,          vec[i].pc);
        check($sformatf("v%0d.rs1", i),     32'(data_out.rs1),    32'(vec[i].rs1));
        check($sformatf("v%0d.rs2", i),     32'(data_out.rs2),    32'(vec[i].rs2));
        check($sformatf("v%0d.rd", i),      32'(data_out.rd),     32'(vec[i].rd));
        check($sformatf("v%0d.imm", i),     data_out.imm,         vec[i].imm);
        check($sformatf("v%0d.aluop", i),   32'(data_out.ALUOp),  32'(vec[i].aluop));
        check($sformatf("v%0d.opcode", i),  32'(data_out.Opcode), 32'(w[6:0]));
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, ".valid"},   32'(valid_out),   32'd0);
        check({tag, ".count"},   32'(count),       32'd0);
        check({tag, ".data"},    32'(|data_out),   32'd0);
        check({tag, ".illegal"}, 32'(illegal_out), 32'd0);
    endtask

    initial begin
        int q[$];
        int idx;

        //            instr         pc          rs1    rs2    rd     imm           aluop
        vec[0] = '{32'hFFF30293, 32'h0000_0000, 5'd6, 5'd0, 5'd5,  32'hFFFF_FFFF, 3'd3}; // ADDI
        vec[1] = '{32'hABCDE1B7, 32'h0000_0100, 5'd0, 5'd0, 5'd3,  32'hABCD_E000, 3'd4}; // LUI
        vec[2] = '{32'h005201B3, 32'h0000_0104, 5'd4, 5'd5, 5'd3,  32'h0000_0000, 3'd2}; // ADD
        vec[3] = '{32'hFF042503, 32'h0000_0108, 5'd8, 5'd0, 5'd10, 32'hFFFF_FFF0, 3'd0}; // LW
        vec[4] = '{32'h00542423, 32'h0000_010C, 5'd8, 5'd5, 5'd0,  32'h0000_0008, 3'd0}; // SW
        vec[5] = '{32'h00209863, 32'h0000_0110, 5'd1, 5'd2, 5'd0,  32'h0000_0010, 3'd1}; // BNE
        vec[6] = '{32'h00C000E7, 32'h0000_0114, 5'd0, 5'd0, 5'd1,  32'h0000_000C, 3'd6}; // JALR
        vec[7] = '{32'h00001517, 32'h0000_0118, 5'd0, 5'd0, 5'd10, 32'h0000_1000, 3'd5}; // AUIPC
        vec[8] = '{32'h008000EF, 32'h0000_011C, 5'd0, 5'd0, 5'd1,  32'h0000_0008, 3'd7}; // JAL

        reset = 1'b1; flush = 1'b0; valid_in = 1'b0; ready_out = 1'b0;
        instr = '0; pc_in = '0;
        tick();
        tick();
        check("rst.ready_in", 32'(ready_in), 32'd0);
        check_reset_state("rst");
        reset = 1'b0;
        tick();
        check("post_rst.ready_in", 32'(ready_in), 32'd1);

        // Single decode with one-cycle latency, then drained.
        drive(0);
        ready_out = 1'b1;
        tick();
        valid_in = 1'b0;
        check_head(0);
        check("single.count", 32'(count), 32'd1);
        tick();
        check("single.drain_count", 32'(count), 32'd0);
        check("single.drain_valid", 32'(valid_out), 32'd0);

        // Format sweep at full throughput.
        for (int i = 1; i <= 8; i++) begin
            drive(i);
            tick();
            check_head(i);
            check($sformatf("sweep%0d.count", i), 32'(count), 32'd1);
        end
        valid_in = 1'b0;
        tick();
        check("sweep.end_count", 32'(count), 32'd0);

        // Fill, backpressure, refused push, in-order drain; two rounds cross the wrap.
        for (int r = 0; r < 2; r++) begin
            ready_out = 1'b0;
            for (int k = 0; k < DEPTH; k++) begin
                drive(r * DEPTH + k);
                tick();
                check($sformatf("fill%0d.count%0d", r, k), 32'(count), 32'(k + 1));
                check($sformatf("fill%0d.head_pc%0d", r, k), data_out.pc, vec[r * DEPTH].pc);
            end
            drive(8);
            #1;
            check($sformatf("fill%0d.full_ready", r), 32'(ready_in), 32'd0);
            tick();
            check($sformatf("fill%0d.extra_count", r), 32'(count), 32'(DEPTH));
            check_head(r * DEPTH);
            valid_in  = 1'b0;
            ready_out = 1'b1;
            for (int k = 0; k < DEPTH; k++) begin
                check_head(r * DEPTH + k);
                tick();
                if (k == 0) check($sformatf("fill%0d.ready_after_pop", r), 32'(ready_in), 32'd1);
                check($sformatf("drain%0d.count%0d", r, k), 32'(count), 32'(DEPTH - 1 - k));
            end
        end

        // Simultaneous push/pop at count 2.
        ready_out = 1'b0;
        drive(0); tick();
        drive(1); tick();
        check("sim.count_start", 32'(count), 32'd2);
        q = {0, 1};
        ready_out = 1'b1;
        for (int c = 0; c < 10; c++) begin
            idx = (2 + c) % 9;
            drive(idx);
            check_head(q[0]);
            tick();
            void'(q.pop_front());
            q.push_back(idx);
            check($sformatf("sim%0d.count", c), 32'(count), 32'd2);
        end
        valid_in = 1'b0;
        while (q.size() > 0) begin
            check_head(q[0]);
            tick();
            void'(q.pop_front());
        end
        check("sim.count_end", 32'(count), 32'd0);

        // Flush at count 3 with a coincident push.
        ready_out = 1'b0;
        drive(0); tick();
        drive(1); tick();
        drive(2); tick();
        check("flush.count_before", 32'(count), 32'd3);
        drive(3);
        flush = 1'b1;
        #1;
        check("flush.ready_during", 32'(ready_in), 32'd0);
        tick();
        flush = 1'b0;
        valid_in = 1'b0;
        #1;
        check("flush.count", 32'(count), 32'd0);
        check("flush.valid", 32'(valid_out), 32'd0);
        check("flush.ready_after", 32'(ready_in), 32'd1);
        tick();
        check("flush.still_empty", 32'(count), 32'd0);
        drive(4);
        tick();
        valid_in = 1'b0;
        check_head(4);
        check("flush.count_one", 32'(count), 32'd1);
        ready_out = 1'b1;
        tick();
        check("flush.drained", 32'(count), 32'd0);

        // Illegal opcode, then reset with two entries buffered.
        ready_out = 1'b0;
        instr = 32'h0000_007F; pc_in = 32'h0000_0200; valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        $display("head illegal instr=0000007f pc=%h illegal=%0d", data_out.pc, illegal_out);
        check("ill.valid",   32'(valid_out),      32'd1);
        check("ill.illegal", 32'(illegal_out),    32'd1);
        check("ill.pc",      data_out.pc,         32'h0000_0200);
        check("ill.rs1",     32'(data_out.rs1),   32'd0);
        check("ill.rs2",     32'(data_out.rs2),   32'd0);
        check("ill.rd",      32'(data_out.rd),    32'd0);
        check("ill.imm",     data_out.imm,        32'd0);
        check("ill.aluop",   32'(data_out.ALUOp), 32'd0);
        drive(5);
        tick();
        valid_in = 1'b0;
        check("ill.count2",       32'(count),       32'd2);
        check("ill.head_illegal", 32'(illegal_out), 32'd1);
        reset = 1'b1;
        #1;
        check("mid_rst.ready_during", 32'(ready_in), 32'd0);
        tick();
        check_reset_state("mid_rst");
        reset = 1'b0;
        tick();
        check("mid_rst.ready_after", 32'(ready_in), 32'd1);
        check("mid_rst.count_after", 32'(count),    32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/decode_buffer.md
# decode_buffer

Registered, parametrised successor to the combinational `decode` stage. Decodes one RV32I instruction per cycle and stores the resulting `decode_data` record in a DEPTH-entry circular FIFO. It drives records to rename/dispatch through a valid/ready handshake and has no combinational path from input to output. A synchronous flush discards all buffered instructions on branch mispredict.

## Interface
- `DEPTH`, default 4: number of FIFO entries. Must be a power of two, ≥2. Pointer width is `$clog2(DEPTH)`.
- `clk` input, 1: clock; all state updates on its rising edge.
- `reset` input, 1: reset; synchronous, active-high.
- `flush` input, 1: synchronous discard of all entries.
- `instr` input, 32: instruction word from fetch.
- `pc_in` input, 32: PC of `instr`.
- `valid_in` input, 1: fetch presents `instr`/`pc_in`.
- `ready_in` output, 1: buffer can accept this cycle.
- `valid_out` output, 1: `data_out` holds a valid record.
- `ready_out` input, 1: downstream consumes `data_out` this cycle.
- `data_out` output, `decode_data`: head record with fields `pc`, `rs1`, `rs2`, `rd`, `imm`, `ALUOp`, `Opcode`, `fu`.
- `illegal_out` output, 1: head record came from an unrecognised opcode.
- `count` output, `$clog2(DEPTH)+1`: number of occupied entries.

## Operation
- **Push.** A push occurs when `valid_in && ready_in`. The decoded record is written at `wr_ptr`, and `wr_ptr` advances modulo DEPTH.
- **Pop.** A pop occurs when `valid_out && ready_out`. `rd_ptr` advances modulo DEPTH.
- **Count update.**
  - Push only: `count` increments.
  - Pop only: `count` decrements.
  - Push and pop together: `count` is unchanged. Legal at any non-full, non-empty occupancy.
- **Control outputs.**
  - `ready_in = !reset && !flush && (count < DEPTH)`. It does not depend on `ready_out`, so a full buffer refuses a push even while popping.
  - `valid_out = (count != 0)`.
  - When empty, `data_out` and `illegal_out` are all-zero.
- **Decode fields (per `Opcode = instr[6:0]`).**
  - Register fields come from `rd=[11:7]`, `rs1=[19:15]`, `rs2=[24:20]`. A field not used by the format is forced to 0.
  - `pc = pc_in`.
- **Decode table (format, immediate, ALUOp):**
  - `0110011` R: imm 0; ALUOp 010.
  - `0010011` I-ALU: rs2=0; imm = sext(instr[31:20]); ALUOp 011.
  - `0000011` load: rs2=0; I-imm; ALUOp 000.
  - `0100011` S: rd=0; imm = sext({[31:25],[11:7]}); ALUOp 000.
  - `1100011` B: rd=0; imm = sext({[31],[7],[30:25],[11:8],0}); ALUOp 001.
  - `0110111` LUI: rs1=rs2=0; imm = {[31:12],12'b0}; ALUOp 100.
  - `0010111` AUIPC: as LUI; ALUOp 101.
  - `1100111` JALR: rs2=0; I-imm; ALUOp 110.
  - `1101111` JAL: rs1=rs2=0; imm = sext({[31],[19:12],[20],[30:21],0}); ALUOp 111.
  - Any other opcode: the record is still buffered with all register fields, imm and ALUOp set to 0, and `illegal_out` is 1 while that record is at the head.
- **Flush.** When `flush` is high at a rising edge, `count`, `wr_ptr` and `rd_ptr` go to 0. A coincident push is dropped and a coincident pop is ignored. Flush wins over push and pop.
- **Reset.** Same effect as flush and has priority over it. Asserting reset mid-operation discards all entries.

## Timing
- **Reset values:** `valid_out`=0, `count`=0, `data_out`=0, `illegal_out`=0. `ready_in`=0 while `reset` is high and 1 in the first cycle after reset deasserts.
- **Latency:** an instruction pushed at edge N is visible on `data_out` with `valid_out`=1 in the cycle following edge N. Minimum latency is 1 cycle.
- **Throughput:** 1 instruction/cycle in steady state when 0 < `count` < DEPTH and both sides handshake.
- **Output stability:** `data_out`, `illegal_out` and `valid_out` change only after a clock edge. While `valid_out && !ready_out`, they hold stable.
- **Wrap-around:** pointers wrap from DEPTH-1 to 0 with no bubble.
- **Full:** `ready_in` drops in the same cycle that `count` reaches DEPTH. It rises in the cycle after the first pop.
- **Flush timing:** `valid_out`=0 and `count`=0 in the cycle after the flush edge. `ready_in` is 0 during the flush cycle and 1 in the next cycle.

## Test plan
- **Single decode:** push ADDI `FFF30293` at pc 0 with `ready_out`=1. Next cycle: `valid_out`=1, rs1=6, rs2=0, rd=5, imm=`FFFFFFFF`, ALUOp=011; then `count` returns to 0.
- **Format sweep:** push the following back-to-back, one per cycle, each with its own pc, and check each record in order:
  - LUI `ABCDE1B7`: imm `ABCDE000`, ALUOp 100.
  - ADD `005201B3`: rs1=4, rs2=5, rd=3, imm 0.
  - LW `FF042503`: imm `FFFFFFF0`.
  - SW `00542423`: rd=0, imm 8.
  - BNE `00209863`: imm `00000010`, ALUOp 001.
  - JALR `00C000E7`: imm `0000000C`, ALUOp 110.
- **Fill and backpressure:** hold `ready_out`=0 and push DEPTH instructions. Require `count`=DEPTH, `ready_in`=0, an extra push not accepted, and `data_out` stable. Then pop all entries in push order and check wrap-around with 2×DEPTH further pushes.
- **Simultaneous push/pop:** at `count`=2, push and pop together for 10 cycles. Require `count` to stay at 2 and records to emerge in order.
- **Flush:** with `count`=3, assert `flush` together with `valid_in`. Next cycle: `count`=0, `valid_out`=0, and the pushed instruction is absent afterward.
- **Illegal opcode and reset:** push `0000007F`. Require `illegal_out`=1 with rs1/rs2/rd/imm=0. Then assert `reset` at `count`=2 and require all outputs to take their reset values.
